decoder_1_2: RTL and testbench
==============================

// Module: decoder_1_2
// PURPOSE
//   1-to-2 line decoder with enable. This is the leaf cell of the register-file
//   write-select tree: decoder2_4 and wider decoders cascade it, feeding each
//   upper out bit into a lower stage's RegWrite.
//   Drives exactly one output high when RegWrite=1; drives all outputs low
//   otherwise.
//   An optional registered mode exists for timing closure at the top of the tree.
// PARAMETERS
//   REGISTERED  0  0: purely combinational decode (clk/rst_n unused);
//                  1: outputs registered on clk, latency 1 cycle
// PORTS
//   clk       input   1  single clock; used only when REGISTERED=1
//   rst_n     input   1  reset, asynchronous, active-low; clears registered outputs
//   in        input   1  select bit
//   RegWrite  input   1  enable; also the cascade input from a parent decoder
//   out       output  2  one-hot-or-zero decoded output
// BEHAVIOUR
//   - Decode function:
//       out[1] = RegWrite &  in
//       out[0] = RegWrite & ~in
//   - Truth table ({in,RegWrite} -> out):
//       00->00, 01->01, 10->00, 11->10
//   - Invariant: out is never 2'b11. With RegWrite=0, out=2'b00 regardless of in.
//   - REGISTERED=0:
//       zero-latency combinational path from in/RegWrite to out.
//       No state; clk and rst_n have no effect.
//       Required default so cascades (upper out -> lower RegWrite) stay single-cycle.
//   - REGISTERED=1:
//       out updates on the rising edge of clk from the decode of in/RegWrite
//       sampled at that edge.
//   - Reset (REGISTERED=1):
//       rst_n=0 forces out=2'b00 immediately, independent of clk.
//       Reset is held while low.
//       The first edge after rst_n rises loads the current decode.
//       Reset asserted mid-operation clears out at once and discards the
//       pending value.
//   - X/Z on in with RegWrite=0 must still yield out=2'b00.
//     X on RegWrite propagates as X (not masked).
//   - Simulation assertion (non-synthesised): out is never 2'b11.
//     When REGISTERED=1, the assertion is disabled while rst_n=0.
// STRUCTURE
//   - Single module; no sub-module.
//   - Decode logic is one continuous assignment to an internal dec[1:0].
//   - A generate block selects either a pass-through of dec or an always_ff
//     stage with asynchronous active-low reset.
//   - Shared package (reg-file decode pkg): localparam DEC_IDLE = 2'b00 and the
//     select-width constants used by decoder2_4 and wider cascades.
//     No typedefs needed.
// TESTING
//   1. REGISTERED=0, sweep {in,RegWrite} 000,001,010,011 (10 time units each)
//      -> out 00,01,00,10 with zero delay.
//   2. REGISTERED=0, RegWrite=0 with in toggling 0/1/X -> out stays 00.
//   3. REGISTERED=1, rst_n=0 with {in,RegWrite}=11 -> out=00 with no clock edge.
//      Release rst_n, one posedge -> out=10.
//   4. REGISTERED=1, apply 01 then 11 on consecutive edges
//      -> out 01 then 10, each one cycle after the input.
//   5. REGISTERED=1, assert rst_n low between edges while out=10
//      -> out=00 immediately; stays 00 until rst_n=1 and the next posedge.
//   6. Cascade check: two instances, upper out[1] feeding lower RegWrite,
//      upper in=1, RegWrite=1, lower in=0 -> lower out=01.
//      The out!=11 assertion never fires in any scenario.

Source files
------------

// File: rtl/decoder_1_2_pkg.sv
// Shared constants for the register-file write-select decode tree.
// decoder_1_2 is the leaf cell; decoder2_4 and wider decoders cascade it.
package decoder_1_2_pkg;

    // Output value of a disabled or reset decoder stage.
    localparam logic [1:0] DEC_IDLE = 2'b00;

    // Select and output widths for each level of the cascade.
    localparam int DEC1_2_SEL_W = 1;
    localparam int DEC1_2_OUT_W = 2;
    localparam int DEC2_4_SEL_W = 2;
    localparam int DEC2_4_OUT_W = 4;
    localparam int DEC3_8_SEL_W = 3;
    localparam int DEC3_8_OUT_W = 8;

    // Number of leaf stages between the root and the outputs of an n-bit select tree.
    function automatic int dec_tree_depth(input int sel_w);
        return sel_w;
    endfunction

endpackage

// File: rtl/decoder_1_2_if.sv
// Select/enable/output bundle of one 1-to-2 decoder stage.
interface decoder_1_2_if;
  import decoder_1_2_pkg::*;

  logic                    in;
  logic                    RegWrite;
  logic [DEC1_2_OUT_W-1:0] out;

  modport master (output in, output RegWrite, input out);
  modport slave  (input in, input RegWrite, output out);
endinterface

// File: rtl/decoder_1_2.sv
// 1-to-2 line decoder with enable; leaf cell of the register-file write-select tree.
// REGISTERED=0 is a zero-latency pass-through, REGISTERED=1 adds one clocked stage.
module decoder_1_2
  import decoder_1_2_pkg::*;
#(
  parameter bit REGISTERED = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  decoder_1_2_if.slave  bus
);

  logic [1:0] w_dec;

  // Plain AND terms keep X on RegWrite visible while RegWrite=0 masks X on in.
  assign w_dec = {bus.RegWrite & bus.in, bus.RegWrite & ~bus.in};

  generate
    if (REGISTERED) begin : g_reg
      logic [1:0] r_out;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out <= DEC_IDLE;
        end else begin
          r_out <= w_dec;
        end
      end

      assign bus.out = r_out;

      assert property (@(posedge clk) disable iff (!rst_n) r_out != 2'b11);
    end else begin : g_comb
      logic w_unused;

      assign w_unused = &{1'b0, clk, rst_n};
      assign bus.out  = w_dec;

      always_comb begin
        assert (w_dec !== 2'b11);
      end
    end
  endgenerate

endmodule

// File: tb/tb_decoder_1_2.sv
// Directed bench for decoder_1_2: combinational, registered and cascaded instances.
module tb_decoder_1_2;
  import decoder_1_2_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  decoder_1_2_if if_comb ();
  decoder_1_2_if if_reg ();
  decoder_1_2_if if_up ();
  decoder_1_2_if if_lo ();

  decoder_1_2 #(.REGISTERED(1'b0)) u_comb (.clk(clk), .rst_n(rst_n), .bus(if_comb.slave));
  decoder_1_2 #(.REGISTERED(1'b1)) u_reg  (.clk(clk), .rst_n(rst_n), .bus(if_reg.slave));
  decoder_1_2 #(.REGISTERED(1'b0)) u_up   (.clk(clk), .rst_n(rst_n), .bus(if_up.slave));
  decoder_1_2 #(.REGISTERED(1'b0)) u_lo   (.clk(clk), .rst_n(rst_n), .bus(if_lo.slave));

  // Upper select line drives the lower stage's enable.
  assign if_lo.RegWrite = if_up.out[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-14s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if_comb.in = 1'b0; if_comb.RegWrite = 1'b0;
    if_reg.in  = 1'b0; if_reg.RegWrite  = 1'b0;
    if_up.in   = 1'b0; if_up.RegWrite   = 1'b0;
    if_lo.in   = 1'b0;

    // Combinational sweep {in,RegWrite}.
    #1;  check("comb_00", if_comb.out, 2'b00);
    if_comb.RegWrite = 1'b1;
    #1;  check("comb_01", if_comb.out, 2'b01);
    #9;
    if_comb.in = 1'b1; if_comb.RegWrite = 1'b0;
    #1;  check("comb_10", if_comb.out, 2'b00);
    #9;
    if_comb.RegWrite = 1'b1;
    #1;  check("comb_11", if_comb.out, 2'b10);
    #9;

    // Disabled decoder ignores in, including X.
    if_comb.RegWrite = 1'b0; if_comb.in = 1'b0;
    #1;  check("comb_dis_0", if_comb.out, 2'b00);
    if_comb.in = 1'b1;
    #1;  check("comb_dis_1", if_comb.out, 2'b00);
    if_comb.in = 1'bx;
    #1;  check("comb_dis_x", if_comb.out, 2'b00);
    if_comb.in = 1'b0;

    // Registered: reset wins over a live 11 input.
    @(negedge clk);
    if_reg.in = 1'b1; if_reg.RegWrite = 1'b1;
    #1;  check("reg_rst_hold", if_reg.out, 2'b00);
    @(posedge clk); #1;
    check("reg_rst_edge", if_reg.out, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;  check("reg_rel_pre", if_reg.out, 2'b00);
    @(posedge clk); #1;
    check("reg_rel_post", if_reg.out, 2'b10);

    // Registered: one-cycle latency on consecutive inputs.
    @(negedge clk);
    if_reg.in = 1'b0; if_reg.RegWrite = 1'b1;
    #1;  check("reg_lat_old", if_reg.out, 2'b10);
    @(posedge clk); #1;
    check("reg_01", if_reg.out, 2'b01);
    @(negedge clk);
    if_reg.in = 1'b1; if_reg.RegWrite = 1'b1;
    #1;  check("reg_lat_hold", if_reg.out, 2'b01);
    @(posedge clk); #1;
    check("reg_11", if_reg.out, 2'b10);

    // Registered: mid-cycle reset clears at once and stays clear.
    #2;
    rst_n = 1'b0;
    #1;  check("reg_async_clr", if_reg.out, 2'b00);
    @(posedge clk); #1;
    check("reg_rst_held", if_reg.out, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;  check("reg_rel2_pre", if_reg.out, 2'b00);
    @(posedge clk); #1;
    check("reg_rel2_post", if_reg.out, 2'b10);

    // Registered: disable is captured as idle.
    @(negedge clk);
    if_reg.RegWrite = 1'b0;
    @(posedge clk); #1;
    check("reg_dis", if_reg.out, 2'b00);

    // Cascade: upper select 1 enables lower stage.
    if_up.in = 1'b1; if_up.RegWrite = 1'b1; if_lo.in = 1'b0;
    #1;  check("casc_up", if_up.out, 2'b10);
    check("casc_lo_01", if_lo.out, 2'b01);
    if_lo.in = 1'b1;
    #1;  check("casc_lo_10", if_lo.out, 2'b10);
    if_up.in = 1'b0;
    #1;  check("casc_up_0", if_up.out, 2'b01);
    check("casc_lo_off", if_lo.out, 2'b00);
    if_up.in = 1'b1; if_up.RegWrite = 1'b0;
    #1;  check("casc_root_off", if_lo.out, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
